// File: rtl/lfsr_pkg.sv
// lfsr shared package
// maximal-length tap table and width limits
package lfsr_pkg;

  localparam int LFSR_MIN_W = 2;
  localparam int LFSR_MAX_W = 32;

  // bit i set: stage i feeds the XOR
  function automatic logic [31:0] max_taps(input int width);
    logic [31:0] t;
    t = '0;
    case (width)
      2:  t = 32'h0000_0003;
      3:  t = 32'h0000_0006;
      4:  t = 32'h0000_000C;
      5:  t = 32'h0000_0014;
      6:  t = 32'h0000_0030;
      7:  t = 32'h0000_0060;
      8:  t = 32'h0000_00B8;
      9:  t = 32'h0000_0110;
      10: t = 32'h0000_0240;
      11: t = 32'h0000_0500;
      12: t = 32'h0000_0829;
      13: t = 32'h0000_100D;
      14: t = 32'h0000_2015;
      15: t = 32'h0000_6000;
      16: t = 32'h0000_B400;
      17: t = 32'h0001_2000;
      18: t = 32'h0002_0400;
      19: t = 32'h0004_0023;
      20: t = 32'h0009_0000;
      21: t = 32'h0014_0000;
      22: t = 32'h0030_0000;
      23: t = 32'h0042_0000;
      24: t = 32'h00E1_0000;
      25: t = 32'h0120_0000;
      26: t = 32'h0200_0023;
      27: t = 32'h0400_0013;
      28: t = 32'h0900_0000;
      29: t = 32'h1400_0000;
      30: t = 32'h2000_0029;
      31: t = 32'h4800_0000;
      32: t = 32'h8020_0003;
      default: t = '0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/lfsr_if.sv
// lfsr state / next-state bundle
// master owns the register, slave computes next
interface lfsr_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] nxt;

  modport master (output state, input nxt);
  modport slave  (input state, output nxt);

endinterface

// File: rtl/lfsr_feedback.sv
// lfsr next-state logic
// tap XOR plus all-zero lock-up recovery
module lfsr_feedback
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = '0,
  parameter logic [WIDTH-1:0] SEED  = '0
) (
  lfsr_if.slave fb_if
);

  logic             zero_d;
  logic             fb_d;
  logic [WIDTH-1:0] next_d;

  // shift toward MSB, feedback into bit 0; zero reloads seed
  always_comb begin
    zero_d = ~|fb_if.state;
    fb_d   = ^(fb_if.state & TAPS);
    next_d = {fb_if.state[WIDTH-2:0], fb_d};
    if (zero_d) next_d = SEED;
  end

  assign fb_if.nxt = next_d;

endmodule

// File: rtl/lfsr.sv
// lfsr top: free-running Fibonacci LFSR
// holds the state register and async reset
module lfsr
  import lfsr_pkg::*;
#(
  parameter int          WIDTH = 4,
  parameter logic [31:0] TAPS  = '0,
  parameter logic [31:0] SEED  = 32'd1
) (
  input  logic             clk,
  input  logic             RSTn,
  output logic [WIDTH-1:0] lfsr_o
);

  localparam logic [WIDTH-1:0] TAPS_EFF =
    (TAPS == '0) ? WIDTH'(max_taps(WIDTH))
                 : TAPS[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_EFF =
    SEED[WIDTH-1:0];

  if (WIDTH < LFSR_MIN_W || WIDTH > LFSR_MAX_W) begin : g_bad_w
    $error("lfsr: WIDTH out of range");
  end
  if (SEED_EFF == '0) begin : g_bad_seed
    $error("lfsr: SEED must be nonzero");
  end

  logic [WIDTH-1:0] state_q;

  lfsr_if #(.WIDTH(WIDTH)) fb_if ();

  assign fb_if.state = state_q;

  lfsr_feedback #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS_EFF),
    .SEED  (SEED_EFF)
  ) u_fb (
    .fb_if (fb_if.slave)
  );

  // advance every cycle; reset loads seed
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) state_q <= SEED_EFF;
    else       state_q <= fb_if.nxt;
  end

  assign lfsr_o = state_q;

endmodule

// File: tb/tb_lfsr.sv
// lfsr testbench
// directed vectors, three configurations
module tb_lfsr;

  logic       clk;
  logic       RSTn;
  logic [3:0] q4;
  logic [7:0] q8;
  logic [4:0] q5;

  int checks;
  int errors;

  lfsr dut (
    .clk    (clk),
    .RSTn   (RSTn),
    .lfsr_o (q4)
  );

  lfsr #(.WIDTH(8), .SEED(32'h01)) u8 (
    .clk    (clk),
    .RSTn   (RSTn),
    .lfsr_o (q8)
  );

  lfsr #(.WIDTH(5), .SEED(32'h0A)) u5 (
    .clk    (clk),
    .RSTn   (RSTn),
    .lfsr_o (q5)
  );

  lfsr_if #(.WIDTH(4)) fbk ();

  lfsr_feedback #(
    .WIDTH (4),
    .TAPS  (4'b1100),
    .SEED  (4'b0001)
  ) u_fbk (
    .fb_if (fbk.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] seq4 [15];
  initial begin
    seq4[0]  = 4'b0010; seq4[1]  = 4'b0100;
    seq4[2]  = 4'b1001; seq4[3]  = 4'b0011;
    seq4[4]  = 4'b0110; seq4[5]  = 4'b1101;
    seq4[6]  = 4'b1010; seq4[7]  = 4'b0101;
    seq4[8]  = 4'b1011; seq4[9]  = 4'b0111;
    seq4[10] = 4'b1111; seq4[11] = 4'b1110;
    seq4[12] = 4'b1100; seq4[13] = 4'b1000;
    seq4[14] = 4'b0001;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    RSTn = 1'b1;
    @(posedge clk);
    #3;
    RSTn = 1'b0;
    #1;
    checks++;
    if (q4 !== 4'b0001) begin
      errors++;
      $display("FAIL reset_async: got %b want 0001", q4);
    end
    checks++;
    if (q5 !== 5'b01010) begin
      errors++;
      $display("FAIL reset_seed5: got %b want 01010", q5);
    end
    step();
    step();
    checks++;
    if (q4 !== 4'b0001) begin
      errors++;
      $display("FAIL reset_hold: got %b want 0001", q4);
    end
  endtask

  task automatic test_sequence();
    bit seen [16];
    for (int i = 0; i < 16; i++) seen[i] = 1'b0;
    seen[1] = 1'b1;
    @(negedge clk);
    RSTn = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      checks++;
      if (q4 !== seq4[i]) begin
        errors++;
        $display("FAIL seq[%0d]: got %b want %b",
                 i, q4, seq4[i]);
      end
      if (i < 14) begin
        checks++;
        if (q4 === 4'b0000 || seen[q4]) begin
          errors++;
          $display("FAIL seq_repeat[%0d]: got %b",
                   i, q4);
        end
        seen[q4] = 1'b1;
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] m;
    logic [3:0] hist [$];
    m = q4;
    for (int i = 0; i < 32; i++) begin
      m = {m[2:0], m[3] ^ m[2]};
      step();
      hist.push_back(q4);
      checks++;
      if (q4 !== m) begin
        errors++;
        $display("FAIL wrap_model[%0d]: got %b want %b",
                 i, q4, m);
      end
      if (i >= 15) begin
        checks++;
        if (q4 !== hist[i-15]) begin
          errors++;
          $display("FAIL wrap_period[%0d]: got %b want %b",
                   i, q4, hist[i-15]);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int n;
    n = 0;
    while (q4 !== 4'b1101 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (q4 !== 4'b1101) begin
      errors++;
      $display("FAIL mid_reach: got %b want 1101", q4);
    end
    #2;
    RSTn = 1'b0;
    #1;
    checks++;
    if (q4 !== 4'b0001) begin
      errors++;
      $display("FAIL mid_async: got %b want 0001", q4);
    end
    @(negedge clk);
    RSTn = 1'b1;
    step();
    checks++;
    if (q4 !== 4'b0010) begin
      errors++;
      $display("FAIL mid_next: got %b want 0010", q4);
    end
  endtask

  task automatic test_lockup();
    @(negedge clk);
    force dut.state_q = 4'b0000;
    #1;
    checks++;
    if (q4 !== 4'b0000) begin
      errors++;
      $display("FAIL lock_forced: got %b want 0000", q4);
    end
    release dut.state_q;
    step();
    checks++;
    if (q4 !== 4'b0001) begin
      errors++;
      $display("FAIL lock_seed: got %b want 0001", q4);
    end
    step();
    checks++;
    if (q4 !== 4'b0010) begin
      errors++;
      $display("FAIL lock_cont: got %b want 0010", q4);
    end
    fbk.state = 4'b0000;
    #1;
    checks++;
    if (fbk.nxt !== 4'b0001) begin
      errors++;
      $display("FAIL fb_zero: got %b want 0001", fbk.nxt);
    end
    fbk.state = 4'b1101;
    #1;
    checks++;
    if (fbk.nxt !== 4'b1010) begin
      errors++;
      $display("FAIL fb_1101: got %b want 1010", fbk.nxt);
    end
  endtask

  task automatic test_sweep();
    int ret8;
    int ret5;
    ret8 = 0;
    ret5 = 0;
    @(negedge clk);
    RSTn = 1'b0;
    #1;
    checks++;
    if (q5 !== 5'b01010) begin
      errors++;
      $display("FAIL w5_first: got %b want 01010", q5);
    end
    @(negedge clk);
    RSTn = 1'b1;
    for (int i = 1; i <= 255; i++) begin
      step();
      if (i == 1) begin
        checks++;
        if (q5 !== 5'b10100) begin
          errors++;
          $display("FAIL w5_e1: got %b want 10100", q5);
        end
      end
      if (i == 2) begin
        checks++;
        if (q5 !== 5'b01000) begin
          errors++;
          $display("FAIL w5_e2: got %b want 01000", q5);
        end
      end
      if (i == 4) begin
        checks++;
        if (q8 !== 8'h11) begin
          errors++;
          $display("FAIL w8_e4: got %h want 11", q8);
        end
      end
      checks++;
      if (q8 === 8'h00 || q5 === 5'h00) begin
        errors++;
        $display("FAIL sweep_zero[%0d]: %h %h",
                 i, q8, q5);
      end
      if (q8 === 8'h01 && ret8 == 0) ret8 = i;
      if (q5 === 5'h0A && ret5 == 0) ret5 = i;
    end
    checks++;
    if (ret8 != 255) begin
      errors++;
      $display("FAIL w8_period: got %0d want 255", ret8);
    end
    checks++;
    if (ret5 != 31) begin
      errors++;
      $display("FAIL w5_period: got %0d want 31", ret5);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    RSTn      = 1'b1;
    fbk.state = 4'b0001;
    test_reset();
    test_sequence();
    test_wrap();
    test_mid_reset();
    test_lockup();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
